// File: rtl/mips_wb_pkg.sv
// Shared types and defaults for the MIPS register-file writeback controller.
package mips_wb_pkg;

    localparam int WB_DEPTH  = 4;
    localparam int WB_ADDR_W = 5;
    localparam int WB_DATA_W = 32;

    localparam logic [WB_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_req_t;

    // Register 0 is hardwired to zero, so writes to it are dropped.
    function automatic logic is_reg_zero(input logic [WB_ADDR_W-1:0] a);
        return a == REG_ZERO;
    endfunction

endpackage

// File: rtl/mips_wb_fifo.sv
// In-order write queue with a per-slot valid vector and flat slot views,
// so the forwarding search can inspect every pending write.
module mips_wb_fifo
    import mips_wb_pkg::*;
#(
    parameter int DEPTH  = WB_DEPTH,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DATA_W = WB_DATA_W,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [ADDR_W-1:0]          push_addr,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic [ADDR_W-1:0]          head_addr,
    output logic [DATA_W-1:0]          head_data,
    output logic [PTR_W-1:0]           rd_ptr,
    output logic [CNT_W-1:0]           count,
    output logic                       full,
    output logic [DEPTH-1:0]           ent_vld,
    output logic [DEPTH*ADDR_W-1:0]    ent_addr,
    output logic [DEPTH*DATA_W-1:0]    ent_data
);

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= push_addr;
            data_mem[wr_ptr] <= push_data;
        end
    end

    assign head_addr = addr_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];
    assign full      = (count == CNT_W'(DEPTH));

    // A slot is live when its distance from the head is below the fill count.
    always_comb begin
        ent_vld  = '0;
        ent_addr = '0;
        ent_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [PTR_W-1:0] off;
            off = PTR_W'(i) - rd_ptr;
            ent_vld[i] = (CNT_W'(off) < count);
            ent_addr[i*ADDR_W +: ADDR_W] = addr_mem[i];
            ent_data[i*DATA_W +: DATA_W] = data_mem[i];
        end
    end

endmodule

// File: rtl/mips_writeback_ctrl.sv
// Register-file write initiator: arbitrates load/ALU results into an in-order
// queue, drains one write per cycle and forwards in-flight values to decode.
module mips_writeback_ctrl
    import mips_wb_pkg::*;
#(
    parameter int DEPTH  = WB_DEPTH,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DATA_W = WB_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_dest,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_dest,
    input  logic [DATA_W-1:0] alu_data,
    output logic [ADDR_W-1:0] write_address,
    output logic [DATA_W-1:0] write_data,
    output logic              WR,
    input  logic [ADDR_W-1:0] fwd_addr_1,
    input  logic [ADDR_W-1:0] fwd_addr_2,
    output logic              fwd_hit_1,
    output logic              fwd_hit_2,
    output logic [DATA_W-1:0] fwd_data_1,
    output logic [DATA_W-1:0] fwd_data_2,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                     ld_fire, alu_fire, push, pop;
    logic [ADDR_W-1:0]        push_addr, head_addr;
    logic [DATA_W-1:0]        push_data, head_data;
    logic [PTR_W-1:0]         rd_ptr;
    logic [CNT_W-1:0]         count;
    logic [DEPTH-1:0]         ent_vld;
    logic [DEPTH*ADDR_W-1:0]  ent_addr;
    logic [DEPTH*DATA_W-1:0]  ent_data;
    logic                     wr_p1;
    logic [ADDR_W-1:0]        addr_p1;
    logic [DATA_W-1:0]        data_p1;

    // Readiness looks only at the registered fill level; load has priority.
    assign ld_ready  = !full;
    assign alu_ready = !full && !ld_valid;
    assign ld_fire   = ld_valid && ld_ready;
    assign alu_fire  = alu_valid && alu_ready;

    always_comb begin
        push      = 1'b0;
        push_addr = alu_dest;
        push_data = alu_data;
        if (ld_fire) begin
            push      = (ld_dest != ADDR_W'(REG_ZERO));
            push_addr = ld_dest;
            push_data = ld_data;
        end else if (alu_fire) begin
            push      = (alu_dest != ADDR_W'(REG_ZERO));
        end
    end

    assign pop = en && (count != '0);

    mips_wb_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_addr (push_addr),
        .push_data (push_data),
        .pop       (pop),
        .head_addr (head_addr),
        .head_data (head_data),
        .rd_ptr    (rd_ptr),
        .count     (count),
        .full      (full),
        .ent_vld   (ent_vld),
        .ent_addr  (ent_addr),
        .ent_data  (ent_data)
    );

    // Output stage p1: register-file write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_p1   <= 1'b0;
            addr_p1 <= '0;
            data_p1 <= '0;
        end else begin
            wr_p1 <= pop;
            if (pop) begin
                addr_p1 <= head_addr;
                data_p1 <= head_data;
            end
        end
    end

    assign WR            = wr_p1;
    assign write_address = addr_p1;
    assign write_data    = data_p1;
    assign empty         = (count == '0) && !wr_p1;

    // Scan oldest to youngest so the last match seen is the youngest write;
    // the output stage is older than anything still queued.
    function automatic logic [DATA_W:0] fwd_search(input logic [ADDR_W-1:0] q);
        logic              hit;
        logic [DATA_W-1:0] data;
        logic [PTR_W-1:0]  idx;
        hit  = 1'b0;
        data = '0;
        if (wr_p1 && addr_p1 == q) begin
            hit  = 1'b1;
            data = data_p1;
        end
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PTR_W'(k);
            if (ent_vld[idx] && ent_addr[idx*ADDR_W +: ADDR_W] == q) begin
                hit  = 1'b1;
                data = ent_data[idx*DATA_W +: DATA_W];
            end
        end
        if (q == ADDR_W'(REG_ZERO)) begin
            hit  = 1'b0;
            data = '0;
        end
        return {hit, data};
    endfunction

    always_comb begin
        {fwd_hit_1, fwd_data_1} = fwd_search(fwd_addr_1);
        {fwd_hit_2, fwd_data_2} = fwd_search(fwd_addr_2);
    end

endmodule
